// File: rtl/tl_c_release_responder.sv
// rtl/tl_c_release_responder.sv - TileLink channel C manager endpoint with ReleaseAck on channel D
module tl_c_release_responder #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_SIZE = 6
) (
   input  logic              clock,
   input  logic              reset_n,
   // channel C from the hart
   input  logic              c_valid,
   output logic              c_ready,
   input  logic [2:0]        c_opcode,
   input  logic [2:0]        c_param,
   input  logic [3:0]        c_size,
   input  logic              c_source,
   input  logic [ADDR_W-1:0] c_address,
   input  logic [DATA_W-1:0] c_data,
   input  logic              c_corrupt,
   // beat stream to the memory-side write buffer
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_corrupt,
   output logic              wb_last,
   // probe acknowledgement notification
   output logic              probe_ack,
   output logic [2:0]        probe_param,
   // channel D back to the hart
   output logic              d_valid,
   input  logic              d_ready,
   output logic [2:0]        d_opcode,
   output logic [1:0]        d_param,
   output logic [3:0]        d_size,
   output logic              d_source,
   output logic              d_denied,
   output logic              d_corrupt,
   // protocol error notification
   output logic              err_illegal
);

   localparam int         BEAT_BYTES  = DATA_W / 8;
   localparam int         LOG2_BEAT   = $clog2(BEAT_BYTES);
   localparam logic [3:0] LOG2_BEAT_L = 4'(LOG2_BEAT);
   localparam logic [3:0] MAX_SIZE_L  = 4'(MAX_SIZE);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;

   localparam logic [2:0] OP_RELEASE_ACK = 3'd6;

   // Index of the final beat for a transfer of 2^size bytes. Sizes that fit
   // in one beat collapse to a single beat (index 0).
   function automatic logic [3:0] last_beat_of(input logic [3:0] size);
      logic [15:0] beats;
      if (size <= LOG2_BEAT_L) begin
         return 4'd0;
      end
      beats = 16'd1 << (size - LOG2_BEAT_L);
      return 4'(beats - 16'd1);
   endfunction

   logic [1:0]        state;
   logic [3:0]        beat_cnt;
   logic [3:0]        last_q;
   logic              release_q;
   logic [2:0]        param_q;
   logic [3:0]        size_q;
   logic              source_q;
   logic [ADDR_W-1:0] base_q;

   // Decode of the message currently presented on channel C.
   // Opcodes 4..7 have bit 2 set; bit 0 marks a data message, bit 1 a Release.
   logic in_illegal;
   logic in_is_data;
   logic in_is_release;
   logic in_single;
   logic c_fire;

   assign in_illegal    = !c_opcode[2] || (c_size > MAX_SIZE_L);
   assign in_is_data    = c_opcode[0];
   assign in_is_release = c_opcode[1];
   assign in_single     = (last_beat_of(c_size) == 4'd0);

   // Beat payload passes straight through; corrupt beats are not special-cased.
   assign wb_data    = c_data;
   assign wb_corrupt = c_corrupt;

   // Channel D carries only ReleaseAck, built from the latched header.
   assign d_valid   = (state == ST_ACK);
   assign d_opcode  = OP_RELEASE_ACK;
   assign d_param   = 2'd0;
   assign d_size    = size_q;
   assign d_source  = source_q;
   assign d_denied  = 1'b0;
   assign d_corrupt = 1'b0;

   // C/write-buffer handshake steering: data beats couple c_ready to wb_ready
   // so a beat only moves when both sides accept in the same cycle.
   always_comb begin
      c_ready  = 1'b0;
      wb_valid = 1'b0;
      wb_last  = 1'b0;
      wb_addr  = base_q + (ADDR_W'(beat_cnt) << LOG2_BEAT);
      case (state)
         ST_IDLE: begin
            if (in_illegal) begin
               c_ready = 1'b1;
            end else if (in_is_data) begin
               c_ready  = wb_ready;
               wb_valid = c_valid;
               wb_addr  = c_address;
               wb_last  = in_single;
            end else begin
               c_ready = 1'b1;
            end
         end
         ST_BURST: begin
            c_ready  = wb_ready;
            wb_valid = c_valid;
            wb_last  = (beat_cnt == last_q);
         end
         default: begin
            c_ready = 1'b0;
         end
      endcase
   end

   assign c_fire = c_valid && c_ready;

   // Message sequencer: header latch, beat counting, ack and pulse generation.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         beat_cnt    <= 4'd0;
         last_q      <= 4'd0;
         release_q   <= 1'b0;
         param_q     <= 3'd0;
         size_q      <= 4'd0;
         source_q    <= 1'b0;
         base_q      <= '0;
         probe_ack   <= 1'b0;
         probe_param <= 3'd0;
         err_illegal <= 1'b0;
      end else begin
         probe_ack   <= 1'b0;
         err_illegal <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (c_fire) begin
                  if (in_illegal) begin
                     err_illegal <= 1'b1;
                  end else begin
                     release_q <= in_is_release;
                     param_q   <= c_param;
                     size_q    <= c_size;
                     source_q  <= c_source;
                     base_q    <= c_address;
                     last_q    <= last_beat_of(c_size);
                     if (in_is_data && !in_single) begin
                        // first beat already went out; continue from beat 1
                        beat_cnt <= 4'd1;
                        state    <= ST_BURST;
                     end else if (in_is_release) begin
                        state <= ST_ACK;
                     end else begin
                        probe_ack   <= 1'b1;
                        probe_param <= c_param;
                     end
                  end
               end
            end
            ST_BURST: begin
               // c_valid low simply stalls here; there is no timeout
               if (c_fire) begin
                  if (beat_cnt == last_q) begin
                     beat_cnt <= 4'd0;
                     if (release_q) begin
                        state <= ST_ACK;
                     end else begin
                        probe_ack   <= 1'b1;
                        probe_param <= param_q;
                        state       <= ST_IDLE;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 4'd1;
                  end
               end
            end
            ST_ACK: begin
               // c_ready is low in ACK, so the next message waits a cycle
               if (d_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tl_c_release_responder.sv
// tb/tb_tl_c_release_responder.sv - directed self-checking bench for tl_c_release_responder
module tb_tl_c_release_responder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        c_valid;
   logic        c_ready;
   logic [2:0]  c_opcode;
   logic [2:0]  c_param;
   logic [3:0]  c_size;
   logic        c_source;
   logic [31:0] c_address;
   logic [31:0] c_data;
   logic        c_corrupt;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_addr;
   logic [31:0] wb_data;
   logic        wb_corrupt;
   logic        wb_last;
   logic        probe_ack;
   logic [2:0]  probe_param;
   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [1:0]  d_param;
   logic [3:0]  d_size;
   logic        d_source;
   logic        d_denied;
   logic        d_corrupt;
   logic        err_illegal;

   int errors = 0;
   int checks = 0;
   int wb_count = 0;
   int d_count = 0;

   tl_c_release_responder #(.DATA_W(32), .ADDR_W(32), .MAX_SIZE(6)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .c_valid     (c_valid),
      .c_ready     (c_ready),
      .c_opcode    (c_opcode),
      .c_param     (c_param),
      .c_size      (c_size),
      .c_source    (c_source),
      .c_address   (c_address),
      .c_data      (c_data),
      .c_corrupt   (c_corrupt),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .wb_corrupt  (wb_corrupt),
      .wb_last     (wb_last),
      .probe_ack   (probe_ack),
      .probe_param (probe_param),
      .d_valid     (d_valid),
      .d_ready     (d_ready),
      .d_opcode    (d_opcode),
      .d_param     (d_param),
      .d_size      (d_size),
      .d_source    (d_source),
      .d_denied    (d_denied),
      .d_corrupt   (d_corrupt),
      .err_illegal (err_illegal)
   );

   always #5 clock = ~clock;

   // count completed handshakes on the write-buffer and D channels
   always @(posedge clock) begin
      if (wb_valid && wb_ready) wb_count <= wb_count + 1;
      if (d_valid && d_ready) d_count <= d_count + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic drive_c(input logic [2:0] op, input logic [3:0] size, input logic src,
                          input logic [2:0] prm, input logic [31:0] addr, input logic [31:0] data);
      c_valid   = 1'b1;
      c_opcode  = op;
      c_size    = size;
      c_source  = src;
      c_param   = prm;
      c_address = addr;
      c_data    = data;
   endtask

   initial begin
      reset_n = 1'b0; c_valid = 1'b0; c_opcode = 3'd4; c_param = 3'd0; c_size = 4'd0;
      c_source = 1'b0; c_address = 32'd0; c_data = 32'd0; c_corrupt = 1'b0;
      wb_ready = 1'b1; d_ready = 1'b0;
      step(); step();
      chk("rst_d_valid", 32'(d_valid), 32'd0);
      chk("rst_probe_ack", 32'(probe_ack), 32'd0);
      chk("rst_err", 32'(err_illegal), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_d_opcode", 32'(d_opcode), 32'd6);
      reset_n = 1'b1;
      step();

      // Release size 6 source 1
      drive_c(3'd6, 4'd6, 1'b1, 3'd1, 32'h0000_1000, 32'd0);
      #1;
      chk("rel_c_ready", 32'(c_ready), 32'd1);
      chk("rel_wb_valid", 32'(wb_valid), 32'd0);
      step();
      c_valid = 1'b0;
      #1;
      chk("rel_d_valid", 32'(d_valid), 32'd1);
      chk("rel_d_opcode", 32'(d_opcode), 32'd6);
      chk("rel_d_size", 32'(d_size), 32'd6);
      chk("rel_d_source", 32'(d_source), 32'd1);
      chk("rel_d_param", 32'(d_param), 32'd0);
      chk("rel_d_denied", 32'({d_denied, d_corrupt}), 32'd0);
      chk("rel_c_ready_ack", 32'(c_ready), 32'd0);
      d_ready = 1'b1;
      step();
      d_ready = 1'b0;
      #1;
      chk("rel_idle", 32'(d_valid), 32'd0);

      // ReleaseData size 4 -> 4 beats; later-beat addresses are junk and ignored
      for (int i = 0; i < 4; i++) begin
         drive_c(3'd7, 4'd4, 1'b0, 3'd0, (i == 0) ? 32'h8000_0040 : 32'hDEAD_0000, 32'h1000 + 32'(i));
         c_corrupt = (i == 2);
         #1;
         chk($sformatf("rd_wb_valid%0d", i), 32'(wb_valid), 32'd1);
         chk($sformatf("rd_addr%0d", i), wb_addr, 32'h8000_0040 + 32'(4 * i));
         chk($sformatf("rd_data%0d", i), wb_data, 32'h1000 + 32'(i));
         chk($sformatf("rd_last%0d", i), 32'(wb_last), (i == 3) ? 32'd1 : 32'd0);
         chk($sformatf("rd_corrupt%0d", i), 32'(wb_corrupt), (i == 2) ? 32'd1 : 32'd0);
         step();
      end
      c_valid = 1'b0; c_corrupt = 1'b0;
      #1;
      chk("rd_d_valid", 32'(d_valid), 32'd1);
      chk("rd_d_size", 32'(d_size), 32'd4);
      chk("rd_d_source", 32'(d_source), 32'd0);
      chk("rd_wb_count", 32'(wb_count), 32'd4);
      d_ready = 1'b1;
      step();
      d_ready = 1'b0;
      #1;
      chk("rd_idle", 32'(d_valid), 32'd0);
      chk("rd_d_count", 32'(d_count), 32'd2);

      // ProbeAckData size 3 -> 2 beats, wb_ready 1,0,1
      drive_c(3'd5, 4'd3, 1'b0, 3'd3, 32'h0000_0100, 32'h0000_00AA);
      wb_ready = 1'b1;
      #1;
      chk("pd_addr0", wb_addr, 32'h0000_0100);
      chk("pd_last0", 32'(wb_last), 32'd0);
      step();
      c_data = 32'h0000_00BB;
      wb_ready = 1'b0;
      #1;
      chk("pd_stall_valid", 32'(wb_valid), 32'd1);
      chk("pd_stall_ready", 32'(c_ready), 32'd0);
      chk("pd_stall_addr", wb_addr, 32'h0000_0104);
      step();
      wb_ready = 1'b1;
      #1;
      chk("pd_ready1", 32'(c_ready), 32'd1);
      chk("pd_last1", 32'(wb_last), 32'd1);
      chk("pd_addr1", wb_addr, 32'h0000_0104);
      chk("pd_no_pulse_yet", 32'(probe_ack), 32'd0);
      step();
      c_valid = 1'b0;
      #1;
      chk("pd_probe_ack", 32'(probe_ack), 32'd1);
      chk("pd_probe_param", 32'(probe_param), 32'd3);
      chk("pd_no_d", 32'(d_valid), 32'd0);
      chk("pd_wb_count", 32'(wb_count), 32'd6);
      step();
      chk("pd_pulse_end", 32'(probe_ack), 32'd0);

      // ProbeAck (no data) -> pulse, stay idle
      drive_c(3'd4, 4'd6, 1'b0, 3'd5, 32'd0, 32'd0);
      #1;
      chk("pa_c_ready", 32'(c_ready), 32'd1);
      step();
      c_valid = 1'b0;
      #1;
      chk("pa_probe_ack", 32'(probe_ack), 32'd1);
      chk("pa_probe_param", 32'(probe_param), 32'd5);
      chk("pa_no_d", 32'(d_valid), 32'd0);

      // illegal opcode 2, then size 7 on a ReleaseData
      drive_c(3'd2, 4'd2, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      chk("il_op_ready", 32'(c_ready), 32'd1);
      chk("il_op_wb", 32'(wb_valid), 32'd0);
      step();
      drive_c(3'd7, 4'd7, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      chk("il_op_err", 32'(err_illegal), 32'd1);
      chk("il_sz_ready", 32'(c_ready), 32'd1);
      chk("il_sz_wb", 32'(wb_valid), 32'd0);
      step();
      c_valid = 1'b0;
      #1;
      chk("il_sz_err", 32'(err_illegal), 32'd1);
      chk("il_sz_no_d", 32'(d_valid), 32'd0);
      step();
      chk("il_err_end", 32'(err_illegal), 32'd0);
      chk("il_wb_count", 32'(wb_count), 32'd6);

      // ReleaseData size 6, reset after 5 beats
      for (int i = 0; i < 5; i++) begin
         drive_c(3'd7, 4'd6, 1'b1, 3'd0, 32'h0000_2000, 32'h2000 + 32'(i));
         #1;
         chk($sformatf("rr_addr%0d", i), wb_addr, 32'h0000_2000 + 32'(4 * i));
         step();
      end
      c_valid = 1'b0;
      reset_n = 1'b0;
      step();
      chk("rr_d_valid", 32'(d_valid), 32'd0);
      chk("rr_probe_ack", 32'(probe_ack), 32'd0);
      chk("rr_err", 32'(err_illegal), 32'd0);
      chk("rr_wb_count", 32'(wb_count), 32'd11);
      reset_n = 1'b1;
      drive_c(3'd6, 4'd2, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      chk("rr_rel_idle_wb", 32'(wb_valid), 32'd0);
      chk("rr_rel_ready", 32'(c_ready), 32'd1);
      step();
      // second Release waits behind the held ack
      drive_c(3'd6, 4'd5, 1'b1, 3'd0, 32'd0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("hold_d_valid%0d", i), 32'(d_valid), 32'd1);
         chk($sformatf("hold_d_size%0d", i), 32'(d_size), 32'd2);
         chk($sformatf("hold_c_ready%0d", i), 32'(c_ready), 32'd0);
         step();
      end
      d_ready = 1'b1;
      #1;
      chk("hs_c_ready", 32'(c_ready), 32'd0);
      step();
      d_ready = 1'b0;
      #1;
      chk("post_hs_d_valid", 32'(d_valid), 32'd0);
      chk("post_hs_c_ready", 32'(c_ready), 32'd1);
      step();
      c_valid = 1'b0;
      #1;
      chk("rel2_d_valid", 32'(d_valid), 32'd1);
      chk("rel2_d_size", 32'(d_size), 32'd5);
      chk("rel2_d_source", 32'(d_source), 32'd1);
      d_ready = 1'b1;
      step();
      d_ready = 1'b0;
      #1;
      chk("final_idle", 32'(d_valid), 32'd0);
      chk("final_d_count", 32'(d_count), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
